// File: rtl/wash_ctrl_param.sv
// Parametrised washing-machine program controller.
// Sequences soap-wait/fill/wash/drain/rinse/spin phases with tick-prescaled phase timers,
// door-open pause/resume and fault reporting. All outputs are registered and decoded from
// the next state, so they line up cycle-for-cycle with state_dbg.
module wash_ctrl_param #(
  parameter int unsigned TW       = 8,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned FILL_T   = 10,
  parameter int unsigned WASH_T   = 40,
  parameter int unsigned DRAIN_T  = 10,
  parameter int unsigned RINSE_T  = 20,
  parameter int unsigned SPIN_T   = 30,
  parameter int unsigned N_RINSE  = 2,
  parameter int unsigned SOAP_TO  = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power,
  input  logic [2:0]    program_selection,
  input  logic          start,
  input  logic          doorclosed,
  input  logic          soap,
  output logic          valve_in_cold,
  output logic          valve_in_hot,
  output logic          valve_out,
  output logic [1:0]    motor,
  output logic [TW-1:0] timer_display,
  output logic          program_done,
  output logic          soap_warning,
  output logic          soap_in,
  output logic          fault,
  output logic [3:0]    state_dbg
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StSoapWait  = 4'd1,
    StFill      = 4'd2,
    StWash      = 4'd3,
    StDrain     = 4'd4,
    StRinseFill = 4'd5,
    StRinse     = 4'd6,
    StSpin      = 4'd7,
    StDone      = 4'd8,
    StPause     = 4'd9
  } state_e;

  // Phases that show their remaining count on the display.
  function automatic logic is_timed(state_e s);
    return s inside {StFill, StWash, StDrain, StRinseFill, StRinse, StSpin};
  endfunction

  // Tick budget loaded on entry to a counting state.
  function automatic logic [TW-1:0] dur(state_e s);
    logic [TW-1:0] d;
    unique case (s)
      StSoapWait:          d = TW'(SOAP_TO);
      StFill, StRinseFill: d = TW'(FILL_T);
      StWash:              d = TW'(WASH_T);
      StDrain:             d = TW'(DRAIN_T);
      StRinse:             d = TW'(RINSE_T);
      StSpin:              d = TW'(SPIN_T);
      default:             d = '0;
    endcase
    return d;
  endfunction

  state_e        state_q, state_d;
  state_e        saved_q, saved_d;
  logic [1:0]    prog_q, prog_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    rinse_q, rinse_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic          soap_in_q, soap_in_d;
  logic          cold_q, cold_d;
  logic          hot_q, hot_d;
  logic          vout_q, vout_d;
  logic [1:0]    motor_q, motor_d;
  logic [TW-1:0] disp_q, disp_d;
  logic          warn_q, warn_d;

  logic tick, expire, counting;

  // Next-state, phase timer and rinse bookkeeping.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    prog_d    = prog_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    rinse_d   = rinse_q;
    done_d    = done_q;
    fault_d   = 1'b0;
    soap_in_d = 1'b0;

    tick     = (presc_q == PW'(TICK_DIV - 1));
    expire   = tick && (cnt_q == TW'(1));
    counting = is_timed(state_q) || (state_q == StSoapWait);

    // The final tick is never consumed here: if the door opens on it, the phase
    // must still expire after resume.
    if (counting && !expire) begin
      if (tick) begin
        presc_d = '0;
        cnt_d   = cnt_q - TW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (program_selection[2]) begin
            fault_d = 1'b1;
          end else if (doorclosed) begin
            prog_d  = program_selection[1:0];
            done_d  = 1'b0;
            rinse_d = '0;
            unique case (program_selection[1:0])
              2'd0, 2'd1: state_d = soap ? StFill : StSoapWait;
              2'd2:       state_d = StRinseFill;
              default:    state_d = StSpin;
            endcase
          end
        end
      end
      StSoapWait: begin
        if (!doorclosed) begin
          state_d = StPause;
          saved_d = state_q;
        end else if (soap) begin
          state_d = StFill;
        end else if (expire) begin
          state_d = StIdle;
          fault_d = 1'b1;
        end
      end
      StPause: begin
        if (doorclosed) state_d = saved_q;
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: begin
        if (!doorclosed) begin
          state_d = StPause;
          saved_d = state_q;
        end else if (expire) begin
          unique case (state_q)
            StFill: begin
              state_d   = StWash;
              soap_in_d = 1'b1;
            end
            StWash:      state_d = StDrain;
            StDrain:     state_d = (rinse_q == 3'(N_RINSE)) ? StSpin : StRinseFill;
            StRinseFill: state_d = StRinse;
            StRinse: begin
              state_d = StDrain;
              rinse_d = rinse_q + 3'd1;
            end
            StSpin:      state_d = StDone;
            default:     state_d = StIdle;
          endcase
        end
      end
    endcase

    // Fresh phase entry reloads the timer; resuming from pause keeps the saved count.
    if ((state_d != state_q) && (state_q != StPause)) begin
      if (is_timed(state_d) || (state_d == StSoapWait)) begin
        cnt_d   = dur(state_d);
        presc_d = '0;
      end else if (state_d != StPause) begin
        cnt_d   = '0;
        presc_d = '0;
      end
    end
  end

  // Output decode from the next state so the registered outputs match state_q.
  always_comb begin
    cold_d  = ((state_d == StFill) && (prog_d == 2'd0)) || (state_d == StRinseFill);
    hot_d   = (state_d == StFill) && (prog_d == 2'd1);
    vout_d  = (state_d == StDrain) || (state_d == StSpin);
    motor_d = 2'b00;
    if ((state_d == StWash) || (state_d == StRinse)) motor_d = 2'b01;
    if (state_d == StSpin) motor_d = 2'b10;
    warn_d  = (state_d == StSoapWait);
    disp_d  = (is_timed(state_d) || ((state_d == StPause) && is_timed(saved_d))) ? cnt_d : '0;
  end

  // State and registered outputs; rst or loss of power forces idle.
  always_ff @(posedge clk) begin
    if (rst || !power) begin
      state_q   <= StIdle;
      saved_q   <= StIdle;
      prog_q    <= '0;
      cnt_q     <= '0;
      presc_q   <= '0;
      rinse_q   <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      soap_in_q <= 1'b0;
      cold_q    <= 1'b0;
      hot_q     <= 1'b0;
      vout_q    <= 1'b0;
      motor_q   <= 2'b00;
      disp_q    <= '0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      prog_q    <= prog_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      rinse_q   <= rinse_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      soap_in_q <= soap_in_d;
      cold_q    <= cold_d;
      hot_q     <= hot_d;
      vout_q    <= vout_d;
      motor_q   <= motor_d;
      disp_q    <= disp_d;
      warn_q    <= warn_d;
    end
  end

  assign valve_in_cold = cold_q;
  assign valve_in_hot  = hot_q;
  assign valve_out     = vout_q;
  assign motor         = motor_q;
  assign timer_display = disp_q;
  assign program_done  = done_q;
  assign soap_warning  = warn_q;
  assign soap_in       = soap_in_q;
  assign fault         = fault_q;
  assign state_dbg     = state_q;

endmodule
